// File: rtl/axi_ram_v2_pkg.sv
// Shared types and constants for the axi_ram_v2 AXI4 slave RAM.
// Sideband widths mirror the legacy AXI width macros used across the interconnect.
package axi_ram_v2_pkg;

  localparam int unsigned AxiProtW   = 3;
  localparam int unsigned AxiCacheW  = 4;
  localparam int unsigned AxiLockW   = 1;
  localparam int unsigned AxiQosW    = 4;
  localparam int unsigned AxiRegionW = 4;

  typedef enum logic [1:0] {
    BurstFixed = 2'b00,
    BurstIncr  = 2'b01,
    BurstWrap  = 2'b10
  } burst_e;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic [1:0] {RIdle, RData, RDrain} r_state_e;

  // Only these lengths form a legal WRAP; anything else degrades to INCR.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI burst address step: next beat address for FIXED/INCR/WRAP and a per-beat
// legality flag (word inside the RAM and beat size no wider than the bus).
module axi_burst_addr_gen
  import axi_ram_v2_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned STRB_WIDTH = 4,
  parameter int unsigned MEM_DEPTH  = 256
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic                  range_ok
);

  localparam int unsigned OffsW = $clog2(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] One = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] size_bytes, aligned, incr, wrap_mask, word_idx;

  always_comb begin
    size_bytes = One << size;
    aligned    = addr & ~(size_bytes - One);
    incr       = aligned + size_bytes;
    wrap_mask  = ((ADDR_WIDTH'(len) + One) << size) - One;
    case (burst_e'(burst))
      BurstFixed: next_addr = addr;
      BurstWrap:  next_addr = wrap_len_ok(len) ? ((addr & ~wrap_mask) | (incr & wrap_mask)) : incr;
      default:    next_addr = incr;
    endcase
    word_idx = addr >> OffsW;
    range_ok = (word_idx < ADDR_WIDTH'(MEM_DEPTH)) && (size <= 3'(OffsW));
  end

endmodule

// File: rtl/axi_ram_v2.sv
// Parametrised AXI4 slave RAM with independent read/write bursts and per-beat SLVERR.
// Define AXI_RAM_OUTPUT_REG_EN for an extra R output register with a 2-entry skid buffer.
module axi_ram_v2
  import axi_ram_v2_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned MEM_DEPTH  = 256
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic [AxiProtW-1:0]   s_axi_awprot,
  input  logic [AxiCacheW-1:0]  s_axi_awcache,
  input  logic [AxiLockW-1:0]   s_axi_awlock,
  input  logic [AxiQosW-1:0]    s_axi_awqos,
  input  logic [AxiRegionW-1:0] s_axi_awregion,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic [AxiProtW-1:0]   s_axi_arprot,
  input  logic [AxiCacheW-1:0]  s_axi_arcache,
  input  logic [AxiLockW-1:0]   s_axi_arlock,
  input  logic [AxiQosW-1:0]    s_axi_arqos,
  input  logic [AxiRegionW-1:0] s_axi_arregion,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam int unsigned OffsW = $clog2(STRB_WIDTH);
  localparam int unsigned IdxW  = $clog2(MEM_DEPTH);

  logic unused_sideband;
  assign unused_sideband = ^{s_axi_awprot, s_axi_awcache, s_axi_awlock, s_axi_awqos,
                             s_axi_awregion, s_axi_arprot, s_axi_arcache, s_axi_arlock,
                             s_axi_arqos, s_axi_arregion};

  // Write channel state
  w_state_e              w_state_q;
  logic                  awready_q, wready_q, bvalid_q, w_err_q;
  logic [1:0]            bresp_q;
  logic [ID_WIDTH-1:0]   bid_q, aw_id_q;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_next_addr;
  logic [7:0]            aw_len_q, w_cnt_q;
  logic [2:0]            aw_size_q;
  logic [1:0]            aw_burst_q;
  logic                  aw_range_ok, w_beat, w_last_beat, w_beat_err;

  axi_burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .STRB_WIDTH (STRB_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_aw_gen (
    .addr      (aw_addr_q),
    .len       (aw_len_q),
    .size      (aw_size_q),
    .burst     (aw_burst_q),
    .next_addr (aw_next_addr),
    .range_ok  (aw_range_ok)
  );

  assign w_beat      = s_axi_wvalid && wready_q && s_axi_aresetn;
  assign w_last_beat = (w_cnt_q == aw_len_q);
  assign w_beat_err  = !aw_range_ok || (s_axi_wlast != w_last_beat);

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      w_state_q  <= WIdle;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RespOkay;
      bid_q      <= '0;
      aw_id_q    <= '0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
      w_cnt_q    <= '0;
      w_err_q    <= 1'b0;
    end else begin
      case (w_state_q)
        WIdle: begin
          awready_q <= 1'b1;
          if (s_axi_awvalid && awready_q) begin
            aw_id_q    <= s_axi_awid;
            aw_addr_q  <= s_axi_awaddr;
            aw_len_q   <= s_axi_awlen;
            aw_size_q  <= s_axi_awsize;
            aw_burst_q <= s_axi_awburst;
            w_cnt_q    <= '0;
            w_err_q    <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b1;
            w_state_q  <= WData;
          end
        end
        WData: begin
          if (w_beat) begin
            aw_addr_q <= aw_next_addr;
            w_cnt_q   <= w_cnt_q + 8'd1;
            w_err_q   <= w_err_q || w_beat_err;
            if (w_last_beat) begin
              wready_q  <= 1'b0;
              bvalid_q  <= 1'b1;
              bresp_q   <= (w_err_q || w_beat_err) ? RespSlverr : RespOkay;
              bid_q     <= aw_id_q;
              w_state_q <= WResp;
            end
          end
        end
        WResp: begin
          if (s_axi_bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            w_state_q <= WIdle;
          end
        end
        default: w_state_q <= WIdle;
      endcase
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_bid     = bid_q;

  // Read channel state; the rd_* registers hold the beat fetched from the RAM
  r_state_e              r_state_q;
  logic                  arready_q;
  logic [ID_WIDTH-1:0]   ar_id_q, rd_id_q;
  logic [ADDR_WIDTH-1:0] ar_addr_q, ar_next_addr;
  logic [7:0]            ar_len_q, r_cnt_q;
  logic [2:0]            ar_size_q;
  logic [1:0]            ar_burst_q, rd_resp_q;
  logic                  ar_range_ok, r_issue, r_slot_free, rd_valid_q, rd_valid_d, rd_last_q;
  logic [DATA_WIDTH-1:0] mem_rdata;

  axi_burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .STRB_WIDTH (STRB_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_ar_gen (
    .addr      (ar_addr_q),
    .len       (ar_len_q),
    .size      (ar_size_q),
    .burst     (ar_burst_q),
    .next_addr (ar_next_addr),
    .range_ok  (ar_range_ok)
  );

  assign r_issue = (r_state_q == RData) && r_slot_free;

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      r_state_q  <= RIdle;
      arready_q  <= 1'b0;
      ar_id_q    <= '0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      r_cnt_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_resp_q  <= RespOkay;
      rd_last_q  <= 1'b0;
      rd_id_q    <= '0;
    end else begin
      case (r_state_q)
        RIdle: begin
          arready_q <= 1'b1;
          if (s_axi_arvalid && arready_q) begin
            ar_id_q    <= s_axi_arid;
            ar_addr_q  <= s_axi_araddr;
            ar_len_q   <= s_axi_arlen;
            ar_size_q  <= s_axi_arsize;
            ar_burst_q <= s_axi_arburst;
            r_cnt_q    <= '0;
            arready_q  <= 1'b0;
            r_state_q  <= RData;
          end
        end
        RData: begin
          if (r_issue) begin
            ar_addr_q <= ar_next_addr;
            r_cnt_q   <= r_cnt_q + 8'd1;
            if (r_cnt_q == ar_len_q) r_state_q <= RDrain;
          end
        end
        RDrain: begin
          if (s_axi_rvalid && s_axi_rready && s_axi_rlast) begin
            arready_q <= 1'b1;
            r_state_q <= RIdle;
          end
        end
        default: r_state_q <= RIdle;
      endcase
      rd_valid_q <= rd_valid_d;
      if (r_issue) begin
        rd_resp_q <= ar_range_ok ? RespOkay : RespSlverr;
        rd_last_q <= (r_cnt_q == ar_len_q);
        rd_id_q   <= ar_id_q;
      end
    end
  end

  // Byte-lane RAM: one write port, one registered read port (read-before-write on collision)
  logic [IdxW-1:0] w_idx, r_idx;
  assign w_idx = aw_addr_q[OffsW +: IdxW];
  assign r_idx = ar_addr_q[OffsW +: IdxW];

  for (genvar g = 0; g < STRB_WIDTH; g++) begin : g_lane
    logic [7:0] lane_q [MEM_DEPTH];
    logic [7:0] rd_byte_q;

    always_ff @(posedge s_axi_aclk) begin
      if (w_beat && aw_range_ok && s_axi_wstrb[g]) lane_q[w_idx] <= s_axi_wdata[8*g +: 8];
    end

    always_ff @(posedge s_axi_aclk) begin
      if (!s_axi_aresetn) begin
        rd_byte_q <= '0;
      end else if (r_issue) begin
        rd_byte_q <= ar_range_ok ? lane_q[r_idx] : 8'h00;
      end
    end

    assign mem_rdata[8*g +: 8] = rd_byte_q;
  end

`ifdef AXI_RAM_OUTPUT_REG_EN
  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } r_beat_t;

  r_beat_t    stage_beat, head_beat;
  r_beat_t    skid_q [2];
  logic [1:0] skid_cnt_q;
  logic       skid_rd_q, skid_wr_q, r_pop;

  assign stage_beat = '{id: rd_id_q, data: mem_rdata, resp: rd_resp_q, last: rd_last_q};
  assign head_beat  = skid_q[skid_rd_q];
  assign r_pop      = (skid_cnt_q != 2'd0) && s_axi_rready;
  // Issue only if the stage beat plus skid contents still fit after this cycle's pop
  assign r_slot_free = (3'(skid_cnt_q) + 3'(rd_valid_q) - 3'(r_pop)) <= 3'd1;
  assign rd_valid_d  = r_issue;

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      skid_q[0]  <= '0;
      skid_q[1]  <= '0;
      skid_cnt_q <= '0;
      skid_rd_q  <= 1'b0;
      skid_wr_q  <= 1'b0;
    end else begin
      if (rd_valid_q) begin
        skid_q[skid_wr_q] <= stage_beat;
        skid_wr_q         <= ~skid_wr_q;
      end
      if (r_pop) skid_rd_q <= ~skid_rd_q;
      skid_cnt_q <= skid_cnt_q + 2'(rd_valid_q) - 2'(r_pop);
    end
  end

  assign s_axi_rvalid = (skid_cnt_q != 2'd0);
  assign s_axi_rid    = head_beat.id;
  assign s_axi_rdata  = head_beat.data;
  assign s_axi_rresp  = head_beat.resp;
  assign s_axi_rlast  = head_beat.last;
`else
  assign r_slot_free  = !rd_valid_q || s_axi_rready;
  assign rd_valid_d   = r_issue || (rd_valid_q && !s_axi_rready);
  assign s_axi_rvalid = rd_valid_q;
  assign s_axi_rid    = rd_id_q;
  assign s_axi_rdata  = mem_rdata;
  assign s_axi_rresp  = rd_resp_q;
  assign s_axi_rlast  = rd_last_q;
`endif

  assign s_axi_arready = arready_q;

endmodule

// File: tb/tb_axi_ram_v2.sv
// Scoreboard bench for axi_ram_v2: directed spec scenarios plus randomized bursts against a
// byte-array reference model.
module tb_axi_ram_v2;
  localparam int DW = 32, AW = 16, IW = 8, SW = 4, DEPTH = 256;

  logic          clk = 1'b0, aresetn = 1'b0;
  logic [IW-1:0] awid = '0, arid = '0, bid, rid;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [7:0]    awlen = '0, arlen = '0;
  logic [2:0]    awsize = '0, arsize = '0;
  logic [1:0]    awburst = '0, arburst = '0, bresp, rresp;
  logic          awvalid = 0, awready, wlast = 0, wvalid = 0, wready, bvalid, bready = 1;
  logic          arvalid = 0, arready, rlast, rvalid, rready = 1;
  logic [DW-1:0] wdata = '0, rdata;
  logic [SW-1:0] wstrb = '0;

  axi_ram_v2 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MEM_DEPTH(DEPTH)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(aresetn),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awprot(3'b0), .s_axi_awcache(4'b0), .s_axi_awlock(1'b0),
    .s_axi_awqos(4'b0), .s_axi_awregion(4'b0), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready), .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
    .s_axi_bready(bready), .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_arprot(3'b0), .s_axi_arcache(4'b0),
    .s_axi_arlock(1'b0), .s_axi_arqos(4'b0), .s_axi_arregion(4'b0), .s_axi_arvalid(arvalid),
    .s_axi_arready(arready), .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [IW-1:0] id; logic [1:0] resp;} b_exp_t;
  typedef struct packed {logic [IW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last;} r_exp_t;

  int          total = 0, bad = 0, r_gaps = 0, rr_mode = 0;
  bit          r_active = 0;
  logic [7:0]  model_mem [DEPTH*SW];
  logic [DW-1:0] wd [16];
  logic [SW-1:0] ws [16];
  b_exp_t      b_q [$];
  r_exp_t      r_q [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Address of beat i, computed directly from the start address rather than stepwise
  function automatic logic [AW-1:0] beat_addr(logic [AW-1:0] start, int len, int size,
                                             logic [1:0] burst, int i);
    int unsigned sz, wl, base, al;
    sz = 1 << size;
    al = int'(start) & ~(sz - 1);
    if (i == 0 || burst == 2'b00) return start;
    if (burst == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      wl   = (len + 1) * sz;
      base = (int'(start) / wl) * wl;
      return AW'(base + ((al - base + i * sz) % wl));
    end
    return AW'(al + i * sz);
  endfunction

  function automatic bit beat_ok(logic [AW-1:0] a, int size);
    return (int'(a >> 2) < DEPTH) && (size <= 2);
  endfunction

  function automatic logic rdy(int ch);
    case (ch)
      0: return awready;
      1: return wready;
      default: return arready;
    endcase
  endfunction

  task automatic wait_hs(input int ch, input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!rdy(ch) && n < 200);
    if (!rdy(ch)) begin
      total++; bad++;
      $display("FAIL %s_timeout: ready=0 after %0d cycles, required 1", name, n);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                          input int size, input logic [1:0] burst, input bit bad_last,
                          input int abort_at);
    logic [AW-1:0] a;
    bit err;
    b_exp_t e;
    err = bad_last;
    for (int i = 0; i <= len; i++) if (!beat_ok(beat_addr(addr, len, size, burst, i), size)) err = 1;
    if (abort_at < 0) begin
      e.id = id; e.resp = err ? 2'b10 : 2'b00;
      b_q.push_back(e);
    end
    @(posedge clk); #1;
    awvalid = 1; awid = id; awaddr = addr; awlen = 8'(len); awsize = 3'(size); awburst = burst;
    wait_hs(0, "aw");
    awvalid = 0;
    for (int i = 0; i <= len; i++) begin
      if (i == abort_at) begin
        wvalid = 0; aresetn = 0;
        repeat (3) @(posedge clk);
        #1 aresetn = 1;
        return;
      end
      wvalid = 1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == len) ^ (bad_last && i == 0);
      wait_hs(1, "w");
      a = beat_addr(addr, len, size, burst, i);
      if (beat_ok(a, size))
        for (int b = 0; b < SW; b++) if (ws[i][b]) model_mem[int'(a >> 2) * SW + b] = wd[i][8*b +: 8];
    end
    wvalid = 0; wlast = 0;
  endtask

  task automatic do_read(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                         input int size, input logic [1:0] burst);
    logic [AW-1:0] a;
    r_exp_t e;
    for (int i = 0; i <= len; i++) begin
      a = beat_addr(addr, len, size, burst, i);
      e.id = id; e.last = (i == len); e.data = '0; e.resp = 2'b10;
      if (beat_ok(a, size)) begin
        e.resp = 2'b00;
        for (int b = 0; b < SW; b++) e.data[8*b +: 8] = model_mem[int'(a >> 2) * SW + b];
      end
      r_q.push_back(e);
    end
    @(posedge clk); #1;
    arvalid = 1; arid = id; araddr = addr; arlen = 8'(len); arsize = 3'(size); arburst = burst;
    wait_hs(2, "ar");
    arvalid = 0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((b_q.size() != 0 || r_q.size() != 0) && n < 3000) begin @(negedge clk); n++; end
    if (b_q.size() != 0 || r_q.size() != 0) begin
      total++; bad++;
      $display("FAIL %s_drain: pending b=%0d r=%0d, required 0", name, b_q.size(), r_q.size());
      b_q.delete(); r_q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  // Monitor: pops and compares whenever a handshake is about to occur
  always @(negedge clk) begin
    b_exp_t be;
    r_exp_t re;
    if (!aresetn) begin
      r_active = 0;
    end else begin
      if (bvalid && bready) begin
        if (b_q.size() == 0) begin
          total++; bad++;
          $display("FAIL b_unexpected: got id=%0h resp=%0d, required none", bid, bresp);
        end else begin
          be = b_q.pop_front();
          check("b_id_resp", {bid, bresp}, be);
        end
      end
      if (r_active && !rvalid) r_gaps++;
      if (rvalid) r_active = !(rready && rlast);
      if (rvalid && rready) begin
        if (r_q.size() == 0) begin
          total++; bad++;
          $display("FAIL r_unexpected: got id=%0h data=%0h, required none", rid, rdata);
        end else begin
          re = r_q.pop_front();
          check("r_beat", {rid, rdata, rresp, rlast}, re);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      case (rr_mode)
        0: rready = 1;
        1: rready = ~rready;
        default: rready = 1'($urandom_range(0, 1));
      endcase
      bready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, size, burst;
    logic [AW-1:0] addr;
    logic [IW-1:0] id;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp, bid, rid,
                            rdata}, '0);
    @(posedge clk); #1 aresetn = 1;

    // Initialise every word so later reads are fully defined
    for (int k = 0; k < DEPTH / 16; k++) begin
      for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      do_write(8'(k), AW'(k * 64), 15, 2, 2'b01, 0, -1);
    end
    wait_idle("fill");

    for (int i = 0; i < 4; i++) begin wd[i] = 32'h11111111 * (i + 1); ws[i] = 4'hF; end
    do_write(8'h5A, 16'h0010, 3, 2, 2'b01, 0, -1); wait_idle("incr_w");
    do_read(8'hA5, 16'h0010, 3, 2, 2'b01); wait_idle("incr_r");

    for (int i = 0; i < 4; i++) begin wd[i] = 32'hC0DE0000 + i; ws[i] = 4'hF; end
    do_write(8'h21, 16'h0008, 3, 2, 2'b10, 0, -1); wait_idle("wrap_w");
    do_read(8'h22, 16'h0008, 3, 2, 2'b10); wait_idle("wrap_r");
    do_read(8'h23, 16'h0000, 3, 2, 2'b01); wait_idle("wrap_r2");

    wd[0] = 32'h000000A1; wd[1] = 32'h0000B200; wd[2] = 32'h00C30000;
    ws[0] = 4'h1; ws[1] = 4'h2; ws[2] = 4'h4;
    do_write(8'h30, 16'h0020, 2, 2, 2'b00, 0, -1); wait_idle("fixed_w");
    do_read(8'h31, 16'h0020, 0, 2, 2'b01); wait_idle("fixed_r");

    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    do_write(8'h40, AW'(DEPTH * 4), 0, 2, 2'b01, 0, -1); wait_idle("oor_w");
    do_read(8'h41, AW'(DEPTH * 4), 0, 2, 2'b01); wait_idle("oor_r");
    do_read(8'h42, AW'(DEPTH * 4 - 8), 3, 2, 2'b01); wait_idle("oor_edge_r");

    wd[0] = 32'h01234567; wd[1] = 32'h89ABCDEF; ws[0] = 4'hF; ws[1] = 4'hF;
    do_write(8'h50, 16'h0040, 1, 2, 2'b01, 1, -1); wait_idle("wlast_w");
    do_read(8'h51, 16'h0040, 1, 2, 2'b01); wait_idle("wlast_r");

    for (int m = 1; m <= 2; m++) begin
      rr_mode = m;
      for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      fork
        do_write(8'h60, 16'h0200, 15, 2, 2'b01, 0, -1);
        do_read(8'h61, 16'h0300, 15, 2, 2'b01);
      join
      wait_idle("concurrent");
    end
    rr_mode = 0;

    for (int i = 0; i < 8; i++) begin wd[i] = 32'hA0A0A0A0 ^ i; ws[i] = 4'hF; end
    do_write(8'h70, 16'h0100, 7, 2, 2'b01, 0, 3);
    do_write(8'h70, 16'h0100, 7, 2, 2'b01, 0, -1); wait_idle("reset_rewrite");
    do_read(8'h71, 16'h0100, 7, 2, 2'b01); wait_idle("reset_read");

    for (int it = 0; it < 40; it++) begin
      rr_mode = it % 3;
      id    = 8'($urandom);
      size  = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      burst = int'($urandom_range(0, 2));
      len   = int'($urandom_range(0, 15));
      case ($urandom_range(0, 7))
        0: addr = AW'(16'hFFF0 + $urandom_range(0, 15));
        1: addr = AW'(DEPTH * 4 - 32 + $urandom_range(0, 31));
        default: addr = AW'($urandom_range(0, DEPTH * 4 - 1));
      endcase
      for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom_range(0, 15)); end
      do_write(id, addr, len, size, 2'(burst), 0, -1); wait_idle("rand_w");
      do_read(~id, addr, len, size, 2'(burst)); wait_idle("rand_r");
    end

    check("r_no_gaps", 128'(r_gaps), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
